// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, idle-high line.
// Bytes arrive over a valid/ready handshake and are latched at acceptance,
// so the source may change tx_data/tx_valid freely while a frame is sent.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit (11-bit frame).
// All outputs come straight from flops; the FSM computes next-state and
// next-output values combinationally and a single register stage holds them.
`timescale 1ns/1ps

module uart_tx #(
    parameter int BASE_FREQ = 50_000_000,
    parameter int BAUDRATE  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = BASE_FREQ / BAUDRATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity: the line bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] clk_cnt_nx;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_nx;
    logic [2:0]       bit_inc;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_reg_nx;
    logic             serial_out_nx;
    logic             tx_ready_nx;
    logic             tx_done_nx;
    logic             bit_last;

    assign bit_last = (clk_cnt == CNT_LAST);
    assign bit_inc  = bit_idx + 3'd1;

    // State and output register; reset drives the line high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'd0;
            serial_out <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nx;
            clk_cnt    <= clk_cnt_nx;
            bit_idx    <= bit_idx_nx;
            shift_reg  <= shift_reg_nx;
            serial_out <= serial_out_nx;
            tx_ready   <= tx_ready_nx;
            tx_busy    <= ~tx_ready_nx;
            tx_done    <= tx_done_nx;
        end
    end

    // Next-state and next-output logic; outputs describe the coming cycle.
    always_comb begin
        state_nx      = state;
        clk_cnt_nx    = clk_cnt;
        bit_idx_nx    = bit_idx;
        shift_reg_nx  = shift_reg;
        serial_out_nx = 1'b1;
        tx_ready_nx   = 1'b0;
        tx_done_nx    = 1'b0;

        case (state)
            IDLE: begin
                tx_ready_nx = 1'b1;
                if (tx_valid && tx_ready) begin
                    state_nx      = START;
                    clk_cnt_nx    = '0;
                    bit_idx_nx    = 3'd0;
                    shift_reg_nx  = tx_data;
                    serial_out_nx = 1'b0;
                    tx_ready_nx   = 1'b0;
                end else begin
                    serial_out_nx = 1'b1;
                end
            end

            START: begin
                if (bit_last) begin
                    state_nx      = DATA;
                    clk_cnt_nx    = '0;
                    bit_idx_nx    = 3'd0;
                    serial_out_nx = shift_reg[0];
                end else begin
                    clk_cnt_nx    = clk_cnt + CNT_W'(1);
                    serial_out_nx = 1'b0;
                end
            end

            DATA: begin
                if (bit_last) begin
                    clk_cnt_nx = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nx      = PARITY;
                        serial_out_nx = even_parity(shift_reg);
`else
                        state_nx      = STOP;
                        serial_out_nx = 1'b1;
`endif
                    end else begin
                        bit_idx_nx    = bit_inc;
                        serial_out_nx = shift_reg[bit_inc];
                    end
                end else begin
                    clk_cnt_nx    = clk_cnt + CNT_W'(1);
                    serial_out_nx = shift_reg[bit_idx];
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_last) begin
                    state_nx      = STOP;
                    clk_cnt_nx    = '0;
                    serial_out_nx = 1'b1;
                end else begin
                    clk_cnt_nx    = clk_cnt + CNT_W'(1);
                    serial_out_nx = even_parity(shift_reg);
                end
            end
`endif

            STOP: begin
                serial_out_nx = 1'b1;
                if (bit_last) begin
                    // Frame complete: ready rises right after the done pulse.
                    state_nx    = IDLE;
                    clk_cnt_nx  = '0;
                    tx_ready_nx = 1'b1;
                end else begin
                    clk_cnt_nx = clk_cnt + CNT_W'(1);
                    // Done occupies the final cycle of the stop bit.
                    tx_done_nx = (clk_cnt_nx == CNT_LAST);
                end
            end

            default: begin
                state_nx      = IDLE;
                clk_cnt_nx    = '0;
                bit_idx_nx    = 3'd0;
                serial_out_nx = 1'b1;
                tx_ready_nx   = 1'b1;
            end
        endcase
    end

endmodule
